// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter definitions: FSM state encodings and default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_STATE_IDLE  = 2'd0,
    UART_STATE_START = 2'd1,
    UART_STATE_DATA  = 2'd2,
    UART_STATE_STOP  = 2'd3
  } uart_state_e;

  // 27 MHz core clock / 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 234;
  localparam int unsigned UART_FIFO_DEPTH_DEFAULT   = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: power-of-two circular buffer, count is the sole full/empty source.
// Latency: pushed byte visible on rdata_o the edge after push when empty; rdata_o is head (show-ahead).
// Backpressure: push while full and pop while empty are ignored; caller observes full_o/empty_o.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  // Acceptance decided on the pre-edge count, so a push while full is lost
  // even if a pop happens on the same edge.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; contents are only read behind a non-zero count.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO from memory-controller stores.
// Latency: write to an empty FIFO with the line idle drives the start bit after the following edge.
// Backpressure: none on writes; a write while full is dropped and sets the sticky overflow flag.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        write_enable,
  input  logic [7:0]                  write_data,
  input  logic                        clear_overflow,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        tx
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  uart_state_e state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          overflow_q;
  logic [1:0]    rst_sync_q;
  logic          run;
  logic          bit_done;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  // Reset release is re-timed through two flops; assertion stays asynchronous.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run      = rst_sync_q[1];
  assign bit_done = (baud_q == BW'(CLKS_PER_BIT - 1));
  // Pop on the pre-edge count only, so a byte written into an empty FIFO
  // is picked up one edge later.
  assign fifo_pop = run && !fifo_empty &&
                    ((state_q == UART_STATE_IDLE) ||
                     ((state_q == UART_STATE_STOP) && bit_done));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (write_enable),
    .pop_i   (fifo_pop),
    .wdata_i (write_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Frame sequencer: baud counter, bit index, shift register and registered line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UART_STATE_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        UART_STATE_IDLE: begin
          baud_q <= '0;
          if (fifo_pop) begin
            shift_q <= fifo_rdata;
            tx_q    <= 1'b0;
            state_q <= UART_STATE_START;
          end
        end
        UART_STATE_START: begin
          if (bit_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= UART_STATE_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        UART_STATE_DATA: begin
          if (bit_done) begin
            baud_q    <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= UART_STATE_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        UART_STATE_STOP: begin
          if (bit_done) begin
            baud_q <= '0;
            if (fifo_pop) begin
              // Back-to-back frame: straight into the next start bit.
              shift_q <= fifo_rdata;
              tx_q    <= 1'b0;
              state_q <= UART_STATE_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= UART_STATE_IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= UART_STATE_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; an explicit clear wins over a same-edge dropped write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          overflow_q <= 1'b0;
    else if (clear_overflow)               overflow_q <= 1'b0;
    else if (write_enable && fifo_full)    overflow_q <= 1'b1;
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != UART_STATE_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: writes push expected bytes, a line monitor decodes frames.
// Latency: directed checks at exact edges relative to each write.
// Backpressure: bench writes only when its scenario says the FIFO has room, except deliberate overflow.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       write_enable;
  logic [7:0] write_data;
  logic       clear_overflow;
  logic       fifo_full;
  logic [3:0] fifo_count;
  logic       busy;
  logic       overflow;
  logic       tx;

  int vectors     = 0;
  int miscompares = 0;
  int frames      = 0;

  logic [7:0] exp_q[$];

  // Line monitor state
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  logic [7:0] mon_byte   = '0;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .clear_overflow (clear_overflow),
    .fifo_full      (fifo_full),
    .fifo_count     (fifo_count),
    .busy           (busy),
    .overflow       (overflow),
    .tx             (tx)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  // Accepted write: expected byte enters the scoreboard.
  task automatic wr(input logic [7:0] d);
    write_enable = 1'b1;
    write_data   = d;
    exp_q.push_back(d);
    tick();
    write_enable = 1'b0;
  endtask

  // Write the bench knows will be dropped (FIFO full).
  task automatic wr_drop(input logic [7:0] d, input logic clr);
    write_enable   = 1'b1;
    write_data     = d;
    clear_overflow = clr;
    tick();
    write_enable   = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || mon_active || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, {busy, mon_active, exp_q.size() == 0}, 3'b001);
    tick_n(3);
  endtask

  // Decode frames on the falling edge: start detect at offset 0, sample mid-bit.
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        check("start_bit", tx, 1'b0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % CPB) == 2) begin
        mon_byte[(mon_cnt - 6) / CPB] = tx;
      end else if (mon_cnt == 38) begin
        check("stop_bit", tx, 1'b1);
        frames++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %0h expected no frame", mon_byte);
        end else begin
          check("frame_byte", mon_byte, exp_q.pop_front());
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int waited;
    reset_n        = 1'b0;
    write_enable   = 1'b0;
    write_data     = '0;
    clear_overflow = 1'b0;
    #12;
    check("rst_tx",       tx,         1'b1);
    check("rst_count",    fifo_count, 4'd0);
    check("rst_full",     fifo_full,  1'b0);
    check("rst_busy",     busy,       1'b0);
    check("rst_overflow", overflow,   1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    tick_n(5);

    // Single byte 0x55
    wr(8'h55);
    check("s_count_n",  fifo_count, 4'd1);
    check("s_tx_n",     tx,         1'b1);
    tick();
    check("s_tx_n1",    tx,         1'b0);
    check("s_count_n1", fifo_count, 4'd0);
    check("s_busy_n1",  busy,       1'b1);
    tick_n(4);
    check("s_bit0",     tx,         1'b1);
    tick_n(4);
    check("s_bit1",     tx,         1'b0);
    tick_n(31);
    check("s_busy_n40", busy,       1'b1);
    check("s_stop",     tx,         1'b1);
    tick();
    check("s_busy_n41", busy,       1'b0);
    check("s_idle_tx",  tx,         1'b1);
    drain("single", 100);

    // Back-to-back 0xA5, 0x3C
    wr(8'hA5);
    check("b_count0", fifo_count, 4'd1);
    wr(8'h3C);
    check("b_count1", fifo_count, 4'd1);
    check("b_start1", tx,         1'b0);
    tick_n(39);
    check("b_stop1",  tx,         1'b1);
    check("b_count_pre", fifo_count, 4'd1);
    tick();
    check("b_start2", tx,         1'b0);
    check("b_count2", fifo_count, 4'd0);
    drain("b2b", 200);

    // Overflow: 9 accepted (one popped), 10th dropped
    for (int i = 0; i < 9; i++) wr(8'h10 + 8'(i));
    check("o_count8", fifo_count, 4'd8);
    check("o_full",   fifo_full,  1'b1);
    check("o_ovf0",   overflow,   1'b0);
    wr_drop(8'hEE, 1'b0);
    check("o_count_drop", fifo_count, 4'd8);
    check("o_ovf1",   overflow,   1'b1);
    wr_drop(8'hEF, 1'b1);
    check("o_clr_prio", overflow, 1'b0);
    wr_drop(8'hF0, 1'b0);
    check("o_ovf_again", overflow, 1'b1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("o_clr",    overflow,   1'b0);
    check("o_count_end", fifo_count, 4'd8);
    drain("overflow", 600);

    // Pointer wrap: 20 bytes, write only while not full
    for (int i = 0; i < 20; i++) begin
      waited = 0;
      while (fifo_full && waited < 200) begin
        tick();
        waited++;
      end
      if (waited >= 200) check("w_wait_timeout", waited, 0);
      wr(8'(i));
    end
    drain("wrap", 1200);

    // Simultaneous write and pop at count 3
    wr(8'hB0);
    wr(8'hB1);
    wr(8'hB2);
    wr(8'hB3);
    check("sp_count3",  fifo_count, 4'd3);
    tick_n(37);
    check("sp_count_pre", fifo_count, 4'd3);
    check("sp_stop",    tx,         1'b1);
    wr(8'hB4);
    check("sp_count_post", fifo_count, 4'd3);
    check("sp_start2",  tx,         1'b0);
    drain("simul", 400);

    // Reset during DATA bit 3 of 0xC3 (bit 3 = 0)
    wr(8'hC3);
    wr(8'h5A);
    wr(8'h69);
    tick_n(15);
    check("r_pre_tx", tx, 1'b0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("r_tx",    tx,         1'b1);
    check("r_count", fifo_count, 4'd0);
    check("r_busy",  busy,       1'b0);
    check("r_full",  fifo_full,  1'b0);
    tick_n(3);
    @(negedge clock);
    reset_n = 1'b1;
    f0 = frames;
    tick_n(100);
    check("r_no_residual", frames - f0, 0);
    check("r_idle_tx", tx,   1'b1);
    check("r_idle_busy", busy, 1'b0);
    wr(8'h96);
    drain("post_reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
